// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath stages.
package mips_pkg;

    // Sequencer stage code on which the memory-access stage runs
    localparam logic [2:0] STAGE_MEM = 3'd3;

    // Memory-access stage controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage.sv
// Multicycle MIPS MEM stage: performs LW/SW over a req/ack data-memory
// port, resolves BEQ/BNE, presents write-back data and pulses stage_done
// once per started instruction.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter logic [2:0]  MEM_STAGE = STAGE_MEM,
    parameter int unsigned TIMEOUT   = 16
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  stage,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        alu_zero,
    input  logic [31:0] branch_target,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic        bne,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] wb_data,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        fault,
    output logic        stage_done
);

    localparam int unsigned    CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   wb_q, wb_d;
    logic          pc_src_q, pc_src_d;
    logic [31:0]   pc_target_q, pc_target_d;
    logic          fault_q, fault_d;
    logic          done_q, done_d;

    logic          is_mem;
    logic          bad_op;

    // Decode the instruction class presented at start
    always_comb begin
        is_mem = mem_read | mem_write;
        bad_op = (mem_read & mem_write) | (is_mem & (alu_result[1:0] != 2'b00));
    end

    // Next-state and registered-output computation for the controller
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_d        = wb_q;
        pc_src_d    = pc_src_q;
        pc_target_d = pc_target_q;
        fault_d     = fault_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (stage == MEM_STAGE) begin
                    addr_d      = {alu_result[31:2], 2'b00};
                    wdata_d     = store_data;
                    pc_target_d = branch_target;
                    pc_src_d    = branch & (alu_zero ^ bne);
                    fault_d     = 1'b0;
                    cnt_d       = '0;
                    if (bad_op) begin
                        // Illegal or misaligned access: report and skip the bus
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (is_mem) begin
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        state_d = ST_REQ;
                    end else begin
                        wb_d    = alu_result;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    // Ack wins over timeout even on the last allowed cycle
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (!we_q) begin
                        wb_d = dmem_rdata;
                    end
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                // Hold here while the sequencer still shows our stage
                if (stage != MEM_STAGE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset_n
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_q        <= '0;
            pc_src_q    <= 1'b0;
            pc_target_q <= '0;
            fault_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_q        <= wb_d;
            pc_src_q    <= pc_src_d;
            pc_target_q <= pc_target_d;
            fault_q     <= fault_d;
            done_q      <= done_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_data    = wb_q;
    assign pc_src     = pc_src_q;
    assign pc_target  = pc_target_q;
    assign fault      = fault_q;
    assign stage_done = done_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus
// randomized instructions checked against a behavioural model.
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  stage;
    logic [31:0] alu_result, store_data, branch_target, dmem_rdata;
    logic        alu_zero, mem_read, mem_write, branch, bne, dmem_ack;
    logic        dmem_req, dmem_we, pc_src, fault, stage_done;
    logic [31:0] dmem_addr, dmem_wdata, wb_data, pc_target;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_wb;

    mem_access_stage #(.MEM_STAGE(3'd3), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .stage(stage),
        .alu_result(alu_result), .store_data(store_data), .alu_zero(alu_zero),
        .branch_target(branch_target), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .bne(bne), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_data(wb_data), .pc_src(pc_src),
        .pc_target(pc_target), .fault(fault), .stage_done(stage_done)
    );

    always #5 clock = ~clock;

    // Run one instruction through the stage. d = index of the REQ cycle
    // (0-based) on which ack is driven; a large d means never.
    // lat counts clocks from the edge that launched stage==3 to stage_done.
    task automatic do_op(
        input  logic rd, input logic wr, input logic br, input logic bn, input logic z,
        input  logic [31:0] alu, input logic [31:0] sd, input logic [31:0] bt,
        input  logic [31:0] rdat, input int d, input bit flip,
        output int lat, output int reqc, output int pulses,
        output logic we_s, output logic [31:0] addr_s, output logic [31:0] wdata_s,
        output bit unstable, output bit hung);
        lat = 1; reqc = 0; pulses = 0; we_s = 1'b0; addr_s = '0; wdata_s = '0;
        unstable = 1'b0; hung = 1'b1;
        mem_read = rd; mem_write = wr; branch = br; bne = bn; alu_zero = z;
        alu_result = alu; store_data = sd; branch_target = bt;
        dmem_ack = 1'b0; stage = 3'd3;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); lat++; @(negedge clock);
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            alu_result = $urandom; store_data = $urandom; branch_target = $urandom;
            if (stage_done) begin
                hung = 1'b0;
                break;
            end
            if (dmem_req) begin
                reqc++;
                if (reqc == 1) begin
                    we_s = dmem_we; addr_s = dmem_addr; wdata_s = dmem_wdata;
                end else if (dmem_we !== we_s || dmem_addr !== addr_s || dmem_wdata !== wdata_s) begin
                    unstable = 1'b1;
                end
                if (flip) stage = 3'd5;
                if (reqc == d + 1) begin
                    dmem_ack = 1'b1; dmem_rdata = rdat;
                end
            end
        end
        if (!hung) begin
            pulses = 1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clock); @(negedge clock);
                if (stage_done) pulses++;
            end
        end
        stage = 3'd0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
        @(posedge clock); @(negedge clock);
        $display("txn rd=%0b wr=%0b br=%0b bne=%0b z=%0b alu=%h ack_idx=%0d lat=%0d req_cycles=%0d fault=%0b wb=%h pc_src=%0b",
                 rd, wr, br, bn, z, alu, d, lat, reqc, fault, wb_data, pc_src);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stage = 3'd0; alu_result = '0; store_data = '0; branch_target = '0;
        alu_zero = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; bne = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0; model_wb = '0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, pc_src, pc_target, fault, stage_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%0b we=%0b addr=%h wdata=%h wb=%h pc_src=%0b tgt=%h fault=%0b done=%0b, want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, pc_src, pc_target, fault, stage_done);
        end
        reset_n = 1'b1;
        // A stray ack while idle must do nothing
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(posedge clock); @(negedge clock);
        dmem_ack = 1'b0;
        n_checks++;
        if ({dmem_req, stage_done, wb_data} !== '0) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got req=%0b done=%0b wb=%h, want 0 0 0", dmem_req, stage_done, wb_data);
        end
    endtask

    task automatic test_lw();
        int lat, reqc, pulses; logic we_s; logic [31:0] a_s, w_s; bit unst, hung;
        do_op(1, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 2, 0,
              lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
        model_wb = 32'hDEADBEEF;
        n_checks++;
        if (hung || reqc != 3 || we_s !== 1'b0 || a_s !== 32'h10 || unst) begin
            n_fail++;
            $display("FAIL lw_request: got hung=%0b req_cycles=%0d we=%0b addr=%h unstable=%0b, want 0 3 0 00000010 0",
                     hung, reqc, we_s, a_s, unst);
        end
        n_checks++;
        if (wb_data !== 32'hDEADBEEF || fault !== 1'b0 || pulses != 1 || lat != 5) begin
            n_fail++;
            $display("FAIL lw_result: got wb=%h fault=%0b pulses=%0d lat=%0d, want deadbeef 0 1 5",
                     wb_data, fault, pulses, lat);
        end
    endtask

    task automatic test_sw();
        int lat, reqc, pulses; logic we_s; logic [31:0] a_s, w_s; bit unst, hung;
        do_op(0, 1, 0, 0, 0, 32'h20, 32'h12345678, 32'h0, 32'h0, 0, 0,
              lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
        n_checks++;
        if (hung || reqc != 1 || we_s !== 1'b1 || a_s !== 32'h20 || w_s !== 32'h12345678) begin
            n_fail++;
            $display("FAIL sw_request: got hung=%0b req_cycles=%0d we=%0b addr=%h wdata=%h, want 0 1 1 00000020 12345678",
                     hung, reqc, we_s, a_s, w_s);
        end
        n_checks++;
        if (lat != 3 || wb_data !== model_wb || fault !== 1'b0 || pulses != 1) begin
            n_fail++;
            $display("FAIL sw_result: got lat=%0d wb=%h fault=%0b pulses=%0d, want 3 %h 0 1",
                     lat, wb_data, fault, pulses, model_wb);
        end
    endtask

    task automatic test_rtype();
        int lat, reqc, pulses; logic we_s; logic [31:0] a_s, w_s; bit unst, hung;
        do_op(0, 0, 0, 0, 0, 32'h55, 32'h0, 32'h0, 32'h0, 0, 0,
              lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
        model_wb = 32'h55;
        n_checks++;
        if (hung || reqc != 0 || wb_data !== 32'h55 || lat != 2 || pulses != 1) begin
            n_fail++;
            $display("FAIL rtype_pass: got hung=%0b req_cycles=%0d wb=%h lat=%0d pulses=%0d, want 0 0 00000055 2 1",
                     hung, reqc, wb_data, lat, pulses);
        end
    endtask

    task automatic test_branch();
        int lat, reqc, pulses; logic we_s; logic [31:0] a_s, w_s; bit unst, hung;
        logic bn_t [3] = '{1'b0, 1'b1, 1'b1};
        logic z_t  [3] = '{1'b1, 1'b1, 1'b0};
        logic exp_t[3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            logic [31:0] bt;
            bt = 32'h0040_0000 + 32'(i * 16);
            do_op(0, 0, 1, bn_t[i], z_t[i], 32'h0, 32'h0, bt, 32'h0, 0, 0,
                  lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
            model_wb = 32'h0;
            n_checks++;
            if (pc_src !== exp_t[i] || pc_target !== bt) begin
                n_fail++;
                $display("FAIL branch_%0d: got pc_src=%0b pc_target=%h, want %0b %h",
                         i, pc_src, pc_target, exp_t[i], bt);
            end
        end
    endtask

    task automatic test_faults();
        int lat, reqc, pulses; logic we_s; logic [31:0] a_s, w_s; bit unst, hung;
        do_op(1, 0, 0, 0, 0, 32'h13, 32'h0, 32'h0, 32'h0, 0, 0,
              lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
        n_checks++;
        if (fault !== 1'b1 || reqc != 0 || lat != 2 || wb_data !== model_wb) begin
            n_fail++;
            $display("FAIL misaligned_lw: got fault=%0b req_cycles=%0d lat=%0d wb=%h, want 1 0 2 %h",
                     fault, reqc, lat, wb_data, model_wb);
        end
        do_op(1, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0,
              lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
        n_checks++;
        if (fault !== 1'b1 || reqc != 0) begin
            n_fail++;
            $display("FAIL rd_and_wr: got fault=%0b req_cycles=%0d, want 1 0", fault, reqc);
        end
    endtask

    task automatic test_timeout();
        int lat, reqc, pulses; logic we_s; logic [31:0] a_s, w_s; bit unst, hung;
        do_op(1, 0, 0, 0, 0, 32'h80, 32'h0, 32'h0, 32'h0, 1000, 0,
              lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
        n_checks++;
        if (hung || reqc != TO || fault !== 1'b1 || dmem_req !== 1'b0 || wb_data !== model_wb) begin
            n_fail++;
            $display("FAIL timeout: got hung=%0b req_cycles=%0d fault=%0b req=%0b wb=%h, want 0 %0d 1 0 %h",
                     hung, reqc, fault, dmem_req, wb_data, TO, model_wb);
        end
        // Ack on the final permitted cycle completes normally
        do_op(1, 0, 0, 0, 0, 32'h84, 32'h0, 32'h0, 32'hA5A5_0001, TO - 1, 0,
              lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
        model_wb = 32'hA5A5_0001;
        n_checks++;
        if (reqc != TO || fault !== 1'b0 || wb_data !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL ack_at_limit: got req_cycles=%0d fault=%0b wb=%h, want %0d 0 a5a50001",
                     reqc, fault, wb_data, TO);
        end
    endtask

    task automatic test_reset_mid_req();
        int lat, reqc, pulses; logic we_s; logic [31:0] a_s, w_s; bit unst, hung;
        mem_read = 1'b1; mem_write = 1'b0; branch = 1'b0; alu_result = 32'h100; stage = 3'd3;
        repeat (3) @(negedge clock);
        n_checks++;
        if (dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_req_setup: got req=%0b, want 1", dmem_req);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_req: got req=%0b, want 0", dmem_req);
        end
        @(negedge clock);
        reset_n = 1'b1; stage = 3'd0; mem_read = 1'b0;
        model_wb = '0;
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        @(posedge clock); @(negedge clock);
        dmem_ack = 1'b0;
        n_checks++;
        if (dmem_req !== 1'b0 || wb_data !== 32'h0 || stage_done !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack_ignored: got req=%0b wb=%h done=%0b, want 0 0 0", dmem_req, wb_data, stage_done);
        end
        do_op(0, 0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 32'h0, 0, 0,
              lat, reqc, pulses, we_s, a_s, w_s, unst, hung);
        model_wb = 32'h77;
        n_checks++;
        if (wb_data !== 32'h77 || lat != 2 || fault !== 1'b0 || pulses != 1) begin
            n_fail++;
            $display("FAIL clean_after_reset: got wb=%h lat=%0d fault=%0b pulses=%0d, want 00000077 2 0 1",
                     wb_data, lat, fault, pulses);
        end
    endtask

    task automatic test_random();
        int lat, reqc, pulses; logic we_s; logic [31:0] a_s, w_s; bit unst, hung;
        for (int n = 0; n < 40; n++) begin
            int kind, d, exp_reqc, exp_lat;
            logic rd, wr, br, bn, z, is_mem, bad, to, exp_fault, exp_pc;
            logic [31:0] alu, sd, bt, rdat;
            bit flip;
            kind = $urandom_range(0, 4);
            alu  = $urandom; sd = $urandom; bt = $urandom; rdat = $urandom;
            br = 1'($urandom); bn = 1'($urandom); z = 1'($urandom);
            d = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4);
            flip = 1'($urandom);
            rd = (kind == 1) || (kind == 3) || (kind == 4);
            wr = (kind == 2) || (kind == 4);
            if (kind == 3) begin
                if (alu[1:0] == 2'b00) alu[0] = 1'b1;
            end else if (kind != 0) begin
                alu[1:0] = 2'b00;
            end
            // Behavioural expectations
            is_mem   = rd | wr;
            bad      = (rd & wr) || (is_mem && alu[1:0] != 2'b00);
            to       = is_mem && !bad && (d >= TO);
            exp_reqc = (!is_mem || bad) ? 0 : ((d >= TO) ? TO : d + 1);
            exp_lat  = 2 + exp_reqc;
            exp_fault = bad | to;
            exp_pc   = br && (z != bn);
            if (!is_mem) model_wb = alu;
            else if (!bad && rd && !to) model_wb = rdat;

            do_op(rd, wr, br, bn, z, alu, sd, bt, rdat, d, flip,
                  lat, reqc, pulses, we_s, a_s, w_s, unst, hung);

            n_checks++;
            if (hung || lat != exp_lat || reqc != exp_reqc || pulses != 1) begin
                n_fail++;
                $display("FAIL rand_%0d_timing: got hung=%0b lat=%0d req_cycles=%0d pulses=%0d, want 0 %0d %0d 1",
                         n, hung, lat, reqc, pulses, exp_lat, exp_reqc);
            end
            n_checks++;
            if (fault !== exp_fault || wb_data !== model_wb || pc_src !== exp_pc || pc_target !== bt) begin
                n_fail++;
                $display("FAIL rand_%0d_result: got fault=%0b wb=%h pc_src=%0b tgt=%h, want %0b %h %0b %h",
                         n, fault, wb_data, pc_src, pc_target, exp_fault, model_wb, exp_pc, bt);
            end
            if (exp_reqc > 0) begin
                n_checks++;
                if (we_s !== wr || a_s !== alu || w_s !== sd || unst) begin
                    n_fail++;
                    $display("FAIL rand_%0d_bus: got we=%0b addr=%h wdata=%h unstable=%0b, want %0b %h %h 0",
                             n, we_s, a_s, w_s, unst, wr, alu, sd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_branch();
        test_faults();
        test_timeout();
        test_reset_mid_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
